// File: rtl/can_rx_fifo.sv
// ---------------------------------------------------------------------------------------------
// can_rx_fifo
//
// Receive-side buffer sitting directly behind the CAN controller. Each one-cycle frame-valid
// pulse is run through an ID acceptance filter. Accepted frames are queued in a DEPTH-entry
// FIFO, and the head frame is presented to the CPU through four 32-bit registers. Back-to-back
// frames therefore no longer overwrite each other.
//
// Optional feature (compile-time macro CAN_RXF_TIMESTAMP_EN):
//   defined   - a 16-bit free-running counter is captured into every pushed entry and returned
//               in rs=1 [31:16]; a control write with d[3]=1 clears the counter.
//   undefined - no counter or timestamp storage; rs=1 [31:16] reads 0 and d[3] is ignored.
//
// Parameters:
//   DEPTH       number of frame entries, power of 2, 2..8
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   frm_valid_i  one-cycle pulse: good frame received
//   frm_id_i     received ID (standard IDs right-aligned in [10:0])
//   frm_ext_i    extended-frame flag
//   frm_rtr_i    remote-frame flag
//   frm_dlc_i    data length code
//   frm_data_i   data bytes 0..7, byte0 in [7:0]
//   cs_i         register access strobe, one cycle
//   wr_i         1 = write, 0 = read (qualified by cs_i)
//   rs_i         register select
//   d_i          write data
//   q_o          read data, 0 when not reading
//   irq_o        interrupt request
//
// Register map:
//   rs=0 read : {ext, rtr, 1'b0, id} of head        write: acc_code
//   rs=1 read : {ts, 4'h0, count, ovf, full, empty, 1'b0, dlc}
//        write: d[0]=pop, d[1]=clear ovf, d[2]=flush, d[3]=clear timestamp counter
//   rs=2 read : head data bytes {3,2,1,0}            write: acc_mask
//   rs=3 read : head data bytes {7,6,5,4}            write: irqen <= d[2:0]
// ---------------------------------------------------------------------------------------------

module can_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frm_valid_i,
  input  logic [28:0] frm_id_i,
  input  logic        frm_ext_i,
  input  logic        frm_rtr_i,
  input  logic [3:0]  frm_dlc_i,
  input  logic [63:0] frm_data_i,
  input  logic        cs_i,
  input  logic        wr_i,
  input  logic [1:0]  rs_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o,
  output logic        irq_o
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DepthCnt = 4'(DEPTH);

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   acc_code_q, acc_code_d;
  logic [31:0]   acc_mask_q, acc_mask_d;
  logic [2:0]    irqen_q, irqen_d;

  // Entry storage; no reset needed, reads are gated by the empty flag.
  logic          mem_ext_q  [DEPTH];
  logic          mem_rtr_q  [DEPTH];
  logic [28:0]   mem_id_q   [DEPTH];
  logic [3:0]    mem_dlc_q  [DEPTH];
  logic [63:0]   mem_data_q [DEPTH];

  // -------------------------------------------------------------------------------------------
  // Decode of the current cycle's events
  // -------------------------------------------------------------------------------------------
  logic empty, full;
  logic accept, frm_acc;
  logic ctl_wr, pop, flush, clr_ovf, clr_ts;
  logic push, ovf_set;

  assign empty = (count_q == 4'd0);
  assign full  = (count_q == DepthCnt);

  // Masked bits must match acc_code; mask bit 31 additionally qualifies the frame format.
  assign accept = (((frm_id_i ^ acc_code_q[28:0]) & acc_mask_q[28:0]) == 29'd0) &&
                  (!acc_mask_q[31] || (frm_ext_i == acc_code_q[31]));
  assign frm_acc = frm_valid_i & accept;

  assign ctl_wr  = cs_i & wr_i & (rs_i == 2'd1);
  assign pop     = ctl_wr & d_i[0] & ~empty;
  assign clr_ovf = ctl_wr & d_i[1];
  assign flush   = ctl_wr & d_i[2];
  assign clr_ts  = ctl_wr & d_i[3];

  // A same-cycle pop frees a slot, so a full FIFO still accepts the frame. Flush discards it.
  assign push    = frm_acc & (~full | pop) & ~flush;
  assign ovf_set = frm_acc & full & ~pop & ~flush;

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    acc_code_d = acc_code_q;
    acc_mask_d = acc_mask_q;
    irqen_d    = irqen_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + {3'b000, push} - {3'b000, pop};
    end

    if (cs_i && wr_i) begin
      case (rs_i)
        2'd0:    acc_code_d = d_i;
        2'd2:    acc_mask_d = d_i;
        2'd3:    irqen_d    = d_i[2:0];
        default: ;
      endcase
    end
  end

  // A new overflow beats a same-cycle clear.
  assign ovf_d = ovf_set | (ovf_q & ~clr_ovf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      ovf_q      <= 1'b0;
      acc_code_q <= 32'd0;
      acc_mask_q <= 32'd0;
      irqen_q    <= 3'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      acc_code_q <= acc_code_d;
      acc_mask_q <= acc_mask_d;
      irqen_q    <= irqen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ext_q[wr_ptr_q]  <= frm_ext_i;
      mem_rtr_q[wr_ptr_q]  <= frm_rtr_i;
      mem_id_q[wr_ptr_q]   <= frm_id_i;
      mem_dlc_q[wr_ptr_q]  <= frm_dlc_i;
      mem_data_q[wr_ptr_q] <= frm_data_i;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Optional receive timestamp
  // -------------------------------------------------------------------------------------------
  logic [15:0] head_ts;

`ifdef CAN_RXF_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_cnt_d;
  logic [15:0] mem_ts_q [DEPTH];

  assign ts_cnt_d = clr_ts ? 16'd0 : ts_cnt_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= 16'd0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ts_q[wr_ptr_q] <= ts_cnt_q;
    end
  end

  assign head_ts = empty ? 16'd0 : mem_ts_q[rd_ptr_q];
`else
  logic unused_clr_ts;
  assign unused_clr_ts = clr_ts;
  assign head_ts       = 16'd0;
`endif

  // -------------------------------------------------------------------------------------------
  // Head view and register read mux
  // -------------------------------------------------------------------------------------------
  logic        head_ext, head_rtr;
  logic [28:0] head_id;
  logic [3:0]  head_dlc;
  logic [63:0] head_data;

  // An empty FIFO presents all-zero head fields rather than a stale entry.
  assign head_ext  = empty ? 1'b0  : mem_ext_q[rd_ptr_q];
  assign head_rtr  = empty ? 1'b0  : mem_rtr_q[rd_ptr_q];
  assign head_id   = empty ? 29'd0 : mem_id_q[rd_ptr_q];
  assign head_dlc  = empty ? 4'd0  : mem_dlc_q[rd_ptr_q];
  assign head_data = empty ? 64'd0 : mem_data_q[rd_ptr_q];

  always_comb begin
    q_o = 32'd0;
    if (cs_i && !wr_i) begin
      case (rs_i)
        2'd0: q_o = {head_ext, head_rtr, 1'b0, head_id};
        2'd1: q_o = {head_ts, 4'h0, count_q, ovf_q, full, empty, 1'b0, head_dlc};
        2'd2: q_o = head_data[31:0];
        2'd3: q_o = head_data[63:32];
        default: q_o = 32'd0;
      endcase
    end
  end

  assign irq_o = (irqen_q[0] & ~empty) | (irqen_q[1] & ovf_q) | (irqen_q[2] & full);

  // Filter register bits 30:29 are storage only; nothing decodes them.
  logic unused_acc;
  assign unused_acc = ^{acc_code_q[30:29], acc_mask_q[30:29]};

endmodule

// File: doc/can_rx_fifo.md
Name: can_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the CAN controller.
- Consumes the controller's one-cycle frame-valid pulse and its frame fields, applies an ID acceptance filter, and queues accepted frames in a DEPTH-entry FIFO.
- Presents the head frame to the CPU on a 4-register, 32-bit bus so back-to-back frames are no longer overwritten.

Parameters:
- DEPTH, 4, number of frame entries; power of 2, range 2..8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frm_valid  in  1  one-cycle pulse: good frame received (CRC ok)
- frm_id  in  29  received ID; standard IDs right-aligned in [10:0]
- frm_ext  in  1  extended-frame flag
- frm_rtr  in  1  remote-frame flag
- frm_dlc  in  4  data length code
- frm_data  in  64  bytes 0..7; byte0 in [7:0]
- cs  in  1  register access strobe, one cycle
- wr  in  1  1 = 32-bit write, 0 = read (qualified by cs)
- rs  in  2  register select
- d  in  32  write data
- q  out  32  read data; 0 when cs=0
- irq  out  1  interrupt request

Behaviour:
- Reset values:
  - FIFO empty: wr_ptr=rd_ptr=count=0.
  - ovf=0, acc_code=0, acc_mask=0 (accept all), irqen=0.
  - q=0, irq=0.
- Acceptance:
  - Accept when ((frm_id ^ acc_code[28:0]) & acc_mask[28:0]) == 0.
  - If acc_mask[31]=1, frm_ext must also equal acc_code[31].
  - Rejected frames: no FIFO change, no flag change.
- Push:
  - Accepted frm_valid with count<DEPTH: entry {ext,rtr,id,dlc,data} written at the wr_ptr edge.
  - wr_ptr increments mod DEPTH; count+1.
  - Entry is visible on reads the next cycle.
- Overflow: accepted frm_valid with count==DEPTH and no same-cycle pop -> frame dropped, ovf<=1 (sticky).
- Register reads (cs & ~wr), combinational q:
  - rs=0: {ext,rtr,1'b0,id} of head.
  - rs=1: {ts[15:0] or 16'h0, 4'h0, count[3:0], ovf, full, empty, 1'b0, dlc}.
  - rs=2: head data bytes {3,2,1,0}.
  - rs=3: head data bytes {7,6,5,4}.
  - When empty, head fields (id, ext, rtr, dlc, data, ts) read as 0.
- Register writes (cs & wr):
  - rs=0: acc_code <= d.
  - rs=2: acc_mask <= d.
  - rs=3: irqen <= d[2:0].
  - rs=1 control bits:
    - d[0]=pop: rd_ptr+1, count-1; ignored when empty.
    - d[1]=clear ovf.
    - d[2]=flush: pointers and count reset to 0.
- Simultaneous events:
  - Push + pop same cycle: both happen, count unchanged. When full, no overflow occurs and the new frame is stored.
  - Flush + push same cycle: flush wins, frame discarded, ovf unchanged.
  - Clear-ovf + new overflow same cycle: ovf stays 1.
  - Pop + flush: flush wins.
- Pointers wrap mod DEPTH. count is 4 bits: 0..DEPTH.
- full = (count==DEPTH); empty = (count==0).
- irq = (irqen[0] & ~empty) | (irqen[1] & ovf) | (irqen[2] & full).
- Reset mid-frame: any pending frm_valid is lost. The async reset clears the FIFO immediately.

Optional Feature:
- Macro CAN_RXF_TIMESTAMP_EN.
- Defined:
  - 16-bit free-running counter ts_cnt, reset 0, increments every clk, wraps at 16'hFFFF.
  - Captured into the entry on push; returned in rs=1 [31:16].
  - Control write rs=1 with d[3]=1 clears ts_cnt to 0 on the next edge.
- Undefined: no counter or storage; rs=1 [31:16] reads 0; d[3] ignored.

Test Plan:
- Reset, then push ID 0x123 std, dlc=2, data 0xBBAA -> rs=0 reads 0x00000123; rs=1 reads count=1, empty=0, dlc=2; rs=2 reads 0x0000BBAA.
- Push DEPTH=4 frames, then a 5th -> full=1, ovf=1; head still holds frame 1. Pop 4 times -> frames 1..4 in order, then empty=1 and rs=0 reads 0.
- acc_code=0x100, acc_mask=0x700 -> ID 0x1FF accepted, ID 0x2FF rejected (count unchanged). With acc_mask[31]=1, acc_code[31]=1: std frame rejected, ext 0x1ABCDEF0 accepted.
- Full FIFO with pop and push in the same cycle -> count stays 4, ovf=0, new frame at tail. Flush and push in the same cycle -> count=0.
- irqen=3'b001 -> irq rises the cycle after the first push and falls after the final pop. irqen=3'b010 -> irq follows ovf until clear-ovf write.
- With CAN_RXF_TIMESTAMP_EN: clear ts, push frame 10 cycles later -> rs=1 [31:16] = 0x000A ±1. Without the macro -> bits read 0.
